amo_mem_arbiter: RTL and testbench

Round-robin arbiter that shares one `amo_shim` + SRAM bank between `NumPorts` requesters (e.g. core data port, debug module, DMA). It sits directly in front of the shim's master side. It sequences the shim's two-cycle AMO commit by blocking all grants during the commit cycle. It also tracks per-port LR/SC reservation ownership, so a store-conditional from a port that does not own the reservation fails locally without reaching memory.

---
 rtl/amo_mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_amo_mem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/amo_mem_arbiter.sv
// amo_mem_arbiter
//   Round-robin arbiter sharing one amo_shim + SRAM bank between NumPorts requesters.
//   Blocks all grants during the shim's AMO commit cycle and tracks LR/SC reservation
//   ownership so a store-conditional from a non-owner fails locally without reaching memory.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i / gnt_o            per-port request (held until granted) / combinational grant
//   add_i, amo_i, wen_i,     per-port request fields (address, AMO opcode, write enable,
//   wdata_i, be_i            write data, byte enable)
//   rvalid_o / rdata_o       per-port response valid (one cycle after grant) / shared data
//   mem_*_o                  winner's request toward the shim
//   mem_gnt_i, mem_rdata_i   shim grant and read data
module amo_mem_arbiter #(
    parameter int unsigned NumPorts     = 3,
    parameter int unsigned AddrMemWidth = 32
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NumPorts-1:0]                      req_i,
    output logic [NumPorts-1:0]                      gnt_o,
    input  logic [NumPorts-1:0][AddrMemWidth-1:0]    add_i,
    input  logic [NumPorts-1:0][3:0]                 amo_i,
    input  logic [NumPorts-1:0]                      wen_i,
    input  logic [NumPorts-1:0][63:0]                wdata_i,
    input  logic [NumPorts-1:0][7:0]                 be_i,
    output logic [NumPorts-1:0]                      rvalid_o,
    output logic [63:0]                              rdata_o,
    output logic                                     mem_req_o,
    output logic [AddrMemWidth-1:0]                  mem_add_o,
    output logic [3:0]                               mem_amo_o,
    output logic                                     mem_wen_o,
    output logic [63:0]                              mem_wdata_o,
    output logic [7:0]                               mem_be_o,
    input  logic                                     mem_gnt_i,
    input  logic [63:0]                              mem_rdata_i
);

    localparam int unsigned PrioW = $clog2(NumPorts);
    // One extra bit so prio + offset can be wrapped without overflow.
    localparam int unsigned CandW = PrioW + 1;

    localparam logic [3:0] AmoNone = 4'h0;
    localparam logic [3:0] AmoLr   = 4'hB;
    localparam logic [3:0] AmoSc   = 4'hC;

    typedef enum logic [0:0] {StIdle, StCommit} state_e;

    state_e                  state_q, state_d;
    logic [PrioW-1:0]        prio_q, prio_d;
    logic                    owner_valid_q, owner_valid_d;
    logic [PrioW-1:0]        owner_q, owner_d;
    logic [AddrMemWidth-1:0] resv_addr_q, resv_addr_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [PrioW-1:0]        rsp_port_q, rsp_port_d;
    logic                    rsp_local_q, rsp_local_d;
    logic                    rsp_upper_q, rsp_upper_d;

    logic [CandW-1:0]        cand;
    logic [PrioW-1:0]        win_idx;
    logic                    any_req;
    logic [3:0]              win_amo;
    logic                    win_wen;
    logic [AddrMemWidth-1:0] win_add;
    logic                    is_lr, is_sc, is_rmw, is_store;
    logic                    win_owns;
    logic                    local_sc;
    logic                    idle;
    logic                    grant;

    // Round-robin scan starting at prio_q, wrapping modulo NumPorts.
    always_comb begin
        win_idx = prio_q;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand = {1'b0, prio_q} + CandW'(i);
            if (cand >= CandW'(NumPorts)) begin
                cand = cand - CandW'(NumPorts);
            end
            if (!any_req && req_i[cand[PrioW-1:0]]) begin
                any_req = 1'b1;
                win_idx = cand[PrioW-1:0];
            end
        end
    end

    assign win_amo  = amo_i[win_idx];
    assign win_wen  = wen_i[win_idx];
    assign win_add  = add_i[win_idx];

    assign is_lr    = (win_amo == AmoLr);
    assign is_sc    = (win_amo == AmoSc);
    assign is_rmw   = (win_amo != AmoNone) && !is_lr && !is_sc;
    assign is_store = win_wen && (win_amo == AmoNone);

    assign win_owns = owner_valid_q && (owner_q == win_idx);
    assign local_sc = is_sc && !win_owns;
    assign idle     = (state_q == StIdle);

    // A local SC is answered here, so it never needs the shim's grant.
    assign mem_req_o = any_req && idle && !local_sc;
    assign grant     = any_req && idle && (mem_gnt_i || local_sc);
    assign gnt_o     = grant ? (NumPorts'(1) << win_idx) : '0;

    assign mem_add_o   = win_add;
    assign mem_amo_o   = win_amo;
    assign mem_wen_o   = win_wen;
    assign mem_wdata_o = wdata_i[win_idx];
    assign mem_be_o    = be_i[win_idx];

    assign rvalid_o = rsp_valid_q ? (NumPorts'(1) << rsp_port_q) : '0;

    always_comb begin
        if (rsp_local_q) begin
            rdata_o = rsp_upper_q ? 64'h0000_0001_0000_0000 : 64'h0000_0000_0000_0001;
        end else begin
            rdata_o = mem_rdata_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        owner_valid_d = owner_valid_q;
        owner_d       = owner_q;
        resv_addr_d   = resv_addr_q;
        rsp_valid_d   = grant;
        rsp_port_d    = win_idx;
        rsp_local_d   = local_sc;
        rsp_upper_d   = be_i[win_idx][4];

        unique case (state_q)
            StIdle: begin
                if (grant && (win_amo != AmoNone) && !is_lr && !local_sc) begin
                    state_d = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (grant) begin
            if (win_idx == PrioW'(NumPorts - 1)) begin
                prio_d = '0;
            end else begin
                prio_d = win_idx + PrioW'(1);
            end

            if (is_lr) begin
                owner_valid_d = 1'b1;
                owner_d       = win_idx;
                resv_addr_d   = win_add;
            end else if (is_sc && win_owns) begin
                owner_valid_d = 1'b0;
            end else if ((is_store || is_rmw) && (owner_q != win_idx)
                         && (win_add == resv_addr_q)) begin
                // Another port wrote the reserved address: the reservation is lost.
                owner_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            prio_q        <= '0;
            owner_valid_q <= 1'b0;
            owner_q       <= '0;
            resv_addr_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_port_q    <= '0;
            rsp_local_q   <= 1'b0;
            rsp_upper_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            owner_valid_q <= owner_valid_d;
            owner_q       <= owner_d;
            resv_addr_q   <= resv_addr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_port_q    <= rsp_port_d;
            rsp_local_q   <= rsp_local_d;
            rsp_upper_q   <= rsp_upper_d;
        end
    end

endmodule

// File: tb/tb_amo_mem_arbiter.sv
// Directed bench for amo_mem_arbiter (3 ports). Expected grants are given per step;
// expected responses go into a scoreboard queue and are checked one cycle later.
module tb_amo_mem_arbiter;

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 32;

    logic                       clk_i = 1'b0;
    logic                       rst_ni;
    logic [NP-1:0]              req_i;
    logic [NP-1:0]              gnt_o;
    logic [NP-1:0][AW-1:0]      add_i;
    logic [NP-1:0][3:0]         amo_i;
    logic [NP-1:0]              wen_i;
    logic [NP-1:0][63:0]        wdata_i;
    logic [NP-1:0][7:0]         be_i;
    logic [NP-1:0]              rvalid_o;
    logic [63:0]                rdata_o;
    logic                       mem_req_o;
    logic [AW-1:0]              mem_add_o;
    logic [3:0]                 mem_amo_o;
    logic                       mem_wen_o;
    logic [63:0]                mem_wdata_o;
    logic [7:0]                 mem_be_o;
    logic                       mem_gnt_i;
    logic [63:0]                mem_rdata_i;

    amo_mem_arbiter #(.NumPorts(NP), .AddrMemWidth(AW)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .add_i      (add_i),
        .amo_i      (amo_i),
        .wen_i      (wen_i),
        .wdata_i    (wdata_i),
        .be_i       (be_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .mem_req_o  (mem_req_o),
        .mem_add_o  (mem_add_o),
        .mem_amo_o  (mem_amo_o),
        .mem_wen_o  (mem_wen_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_be_o   (mem_be_o),
        .mem_gnt_i  (mem_gnt_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          due;
        logic [2:0]  port;
        logic [63:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;

    localparam int KFwd   = 0;
    localparam int KLocLo = 1;
    localparam int KLocHi = 2;

    function automatic logic [63:0] pat(input int c);
        return {32'hD00D_0000 + 32'(c), ~32'(c)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp)
        else begin
            nfail++;
            $error("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle: inputs were set at the preceding negedge.
    task automatic tick(input string tag, input logic [2:0] exp_gnt, input logic exp_mreq,
                        input int kind);
        rsp_t       e;
        logic [2:0] seen;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk({tag, ".rvalid"}, 64'(rvalid_o), 64'(e.port));
            chk({tag, ".rdata"}, rdata_o, e.data);
        end else begin
            chk({tag, ".rvalid0"}, 64'(rvalid_o), 64'h0);
        end
        chk({tag, ".gnt"}, 64'(gnt_o), 64'(exp_gnt));
        chk({tag, ".mem_req"}, 64'(mem_req_o), 64'(exp_mreq));
        if (exp_gnt != 3'b000) begin
            e.due  = cyc + 1;
            e.port = exp_gnt;
            e.data = (kind == KFwd)   ? pat(cyc + 1) :
                     (kind == KLocLo) ? 64'h0000_0000_0000_0001 : 64'h0000_0001_0000_0000;
            sb.push_back(e);
        end
        seen = gnt_o;
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        mem_rdata_i = pat(cyc);
        req_i = req_i & ~seen;
    endtask

    task automatic set_port(input int p, input logic [3:0] amo, input logic wen,
                            input logic [31:0] addr, input logic [7:0] be);
        req_i[p]   = 1'b1;
        amo_i[p]   = amo;
        wen_i[p]   = wen;
        add_i[p]   = addr;
        be_i[p]    = be;
        wdata_i[p] = {32'hBEEF_0000, addr};
    endtask

    initial begin
        rst_ni      = 1'b0;
        req_i       = '0;
        add_i       = '0;
        amo_i       = '0;
        wen_i       = '0;
        wdata_i     = '0;
        be_i        = '0;
        mem_gnt_i   = 1'b1;
        mem_rdata_i = pat(0);
        #1;
        chk("rst.rvalid", 64'(rvalid_o), 64'h0);
        chk("rst.gnt", 64'(gnt_o), 64'h0);
        chk("rst.mem_req", 64'(mem_req_o), 64'h0);
        chk("rst.prio", 64'(dut.prio_q), 64'h0);
        chk("rst.owner_valid", 64'(dut.owner_valid_q), 64'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // All ports load every cycle: 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < 3; p++) set_port(p, 4'h0, 1'b0, 32'h100 + 32'(p), 8'hFF);
            tick("rr", 3'b001 << (i % 3), 1'b1, KFwd);
        end

        // Shim stall: request visible, no grant until mem_gnt_i.
        set_port(0, 4'h0, 1'b0, 32'h200, 8'hFF);
        mem_gnt_i = 1'b0;
        tick("stall", 3'b000, 1'b1, KFwd);
        mem_gnt_i = 1'b1;
        tick("stall_rel", 3'b001, 1'b1, KFwd);

        // prio=1: port 1 AMOAdd vs loads on 0 and 2.
        set_port(0, 4'h0, 1'b0, 32'h300, 8'hFF);
        set_port(1, 4'h2, 1'b1, 32'h304, 8'hFF);
        set_port(2, 4'h0, 1'b0, 32'h308, 8'hFF);
        tick("amo.g1", 3'b010, 1'b1, KFwd);
        tick("amo.commit", 3'b000, 1'b0, KFwd);
        tick("amo.g2", 3'b100, 1'b1, KFwd);
        tick("amo.g0", 3'b001, 1'b1, KFwd);
        amo_i = '0;
        wen_i = '0;

        // LR then SC from the same port: both forwarded.
        set_port(0, 4'hB, 1'b0, 32'h40, 8'hFF);
        tick("lr0", 3'b001, 1'b1, KFwd);
        chk("lr0.owner_valid", 64'(dut.owner_valid_q), 64'h1);
        chk("lr0.owner", 64'(dut.owner_q), 64'h0);
        set_port(0, 4'hC, 1'b1, 32'h40, 8'hFF);
        tick("sc0", 3'b001, 1'b1, KFwd);
        tick("sc0.commit", 3'b000, 1'b0, KFwd);
        chk("sc0.owner_valid", 64'(dut.owner_valid_q), 64'h0);

        // SC from non-owner port 2 with be=F0: local failure in upper word.
        set_port(0, 4'hB, 1'b0, 32'h40, 8'hFF);
        tick("lr0b", 3'b001, 1'b1, KFwd);
        set_port(2, 4'hC, 1'b1, 32'h40, 8'hF0);
        tick("sc2.local", 3'b100, 1'b0, KLocHi);
        tick("sc2.rsp", 3'b000, 1'b0, KFwd);
        chk("sc2.owner_valid", 64'(dut.owner_valid_q), 64'h1);
        chk("sc2.owner", 64'(dut.owner_q), 64'h0);

        // Store by port 1 to the reserved address kills port 0's reservation.
        set_port(1, 4'h0, 1'b1, 32'h40, 8'hFF);
        tick("st1", 3'b010, 1'b1, KFwd);
        chk("st1.owner_valid", 64'(dut.owner_valid_q), 64'h0);
        set_port(0, 4'hC, 1'b1, 32'h40, 8'h0F);
        tick("sc0.local", 3'b001, 1'b0, KLocLo);
        tick("sc0l.rsp", 3'b000, 1'b0, KFwd);

        // Reset while in Commit drops the pending response.
        set_port(1, 4'h3, 1'b1, 32'h80, 8'hFF);
        tick("rmw1", 3'b010, 1'b1, KFwd);
        rst_ni = 1'b0;
        #1;
        chk("rstc.rvalid", 64'(rvalid_o), 64'h0);
        chk("rstc.prio", 64'(dut.prio_q), 64'h0);
        chk("rstc.gnt", 64'(gnt_o), 64'h0);
        sb.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        amo_i  = '0;
        wen_i  = '0;
        set_port(2, 4'h0, 1'b0, 32'h90, 8'hFF);
        tick("post_rst", 3'b100, 1'b1, KFwd);
        tick("post_rst.rsp", 3'b000, 1'b0, KFwd);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
